fpu_issue_stage: RTL

//  Operand-issue stage directly upstream of coprocessor1 (the FP ALU). Holds the 32-entry FP register

---
 rtl/fpu_issue_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/fpu_issue_stage.sv
// Operand-issue stage feeding the FP ALU (coprocessor1).
// Holds the FP register file and a busy scoreboard. It accepts instructions over
// valid/ready and registers the operands, op code and destination tag into the
// execute register. ALU results come back on the writeback port.
module fpu_issue_stage #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] issue_fs,
    input  logic [ADDR_W-1:0] issue_ft,
    input  logic [ADDR_W-1:0] issue_fd,
    input  logic [OP_W-1:0]   issue_op,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [OP_W-1:0]   FloatALUop,
    output logic [ADDR_W-1:0] ex_fd,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_fd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] reg_file [NREGS];
    logic [NREGS-1:0]  busy_reg;
    logic [NREGS-1:0]  busy_next;
    logic [NREGS-1:0]  wb_hit;
    logic [NREGS-1:0]  ebusy;
    logic              stall;
    logic              fire;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;

    // One-hot decode of the writeback target, plus one storage word per register.
    // The register file is reset, so it stays in flops rather than block RAM.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
        assign wb_hit[gi] = wb_valid && (wb_fd == ADDR_W'(gi));

        // Write the returning ALU result into this register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                reg_file[gi] <= '0;
            end else if (wb_hit[gi]) begin
                reg_file[gi] <= wb_data;
            end
        end
    end

    // A register whose result arrives this cycle no longer blocks issue.
    assign ebusy = busy_reg & ~wb_hit;

    // Sources cover RAW hazards. The destination covers WAW hazards.
    assign stall       = ebusy[issue_fs] | ebusy[issue_ft] | ebusy[issue_fd];
    assign issue_ready = ~stall & (~ex_valid | ex_ready);
    assign fire        = issue_valid & issue_ready;

    // Forward same-cycle writeback data around the register file.
    assign operand_a = (wb_valid && (wb_fd == issue_fs)) ? wb_data : reg_file[issue_fs];
    assign operand_b = (wb_valid && (wb_fd == issue_ft)) ? wb_data : reg_file[issue_ft];

    assign dbg_data = reg_file[dbg_addr];

    // Scoreboard update. A new issue to the same register overrides a writeback clear.
    always_comb begin
        busy_next = busy_reg;
        if (wb_valid) begin
            busy_next[wb_fd] = 1'b0;
        end
        if (fire) begin
            busy_next[issue_fd] = 1'b1;
        end
    end

    // Register the scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Execute pipeline register. Its payload holds while it is stalled or empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            data1      <= '0;
            data2      <= '0;
            FloatALUop <= '0;
            ex_fd      <= '0;
        end else if (fire) begin
            ex_valid   <= 1'b1;
            data1      <= operand_a;
            data2      <= operand_b;
            FloatALUop <= issue_op;
            ex_fd      <= issue_fd;
        end else if (ex_ready) begin
            ex_valid   <= 1'b0;
        end
    end

endmodule
